iram_fetch_arbiter: RTL and testbench

- Owns the bytecode instruction RAM (iram) and shares its single port between two requesters: the JIT decode state machine, which reads bytecode sequentially, and the host loader, which writes bytecode into iram.
- Holds the JVM bytecode PC and sequences reads using a fixed RAM read latency.
- Drives the `waiting` stall and `iram_data` byte consumed by the decode state machine.

---
 rtl/iram_fetch_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_iram_fetch_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_fetch_arbiter.sv
// iram_fetch_arbiter: owns the single-port bytecode iram and shares it
// between the JIT decode fetch path and the host bytecode loader.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   fetch_req         decode SM asks for the byte at pc (level)
//   iram_data         last delivered byte, held until the next delivery
//   waiting           stall to the decode SM while a fetch is outstanding
//   pc                bytecode PC, address of the next byte to fetch
//   pc_load/_val      branch or method entry, overrides everything else
//   host_wr/addr/data host write request (level), host_ack one-cycle pulse
//   ram_*             registered iram port, one-cycle ram_en per access
//
// Optional feature (macro IRAM_FETCH_LIMIT_EN): adds pc_limit input and a
// sticky fetch_fault output for fetches at or beyond pc_limit or past the
// top of the address space. Without the macro the PC wraps silently.
module iram_fetch_arbiter #(
   parameter int                ADDR_W   = 12,
   // read latency in cycles, legal range 1..4
   parameter int                RD_LAT   = 2,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   output logic [7:0]        iram_data,
   output logic              waiting,
   output logic [ADDR_W-1:0] pc,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_val,
   input  logic              host_wr,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_data,
   output logic              host_ack,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
`ifdef IRAM_FETCH_LIMIT_EN
   input  logic [ADDR_W-1:0] pc_limit,
   output logic              fetch_fault,
`endif
   input  logic [7:0]        ram_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      HOST
   } state_t;

   localparam logic GNT_FETCH = 1'b0;
   localparam logic GNT_HOST  = 1'b1;

   state_t            state, state_nxt;
   logic [2:0]        lat_cnt, lat_nxt;
   logic              last_grant, last_nxt;
   logic              discard, discard_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic [7:0]        data_nxt;
   logic              wait_nxt;
   logic              ack_nxt;
   logic              en_nxt;
   logic              we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [7:0]        wdata_nxt;
   logic              fault;
   logic              fetch_ok;
   logic              issue;
   logic              deliver;

`ifdef IRAM_FETCH_LIMIT_EN
   logic              fault_nxt;
   assign fetch_fault = fault;
`else
   assign fault = 1'b0;
`endif

   // a faulted fetch path stops competing for the port
   assign fetch_ok = fetch_req && !fault;

   always_comb begin
      state_nxt   = state;
      lat_nxt     = lat_cnt;
      last_nxt    = last_grant;
      discard_nxt = discard;
      pc_nxt      = pc;
      data_nxt    = iram_data;
      ack_nxt     = 1'b0;
      en_nxt      = 1'b0;
      we_nxt      = 1'b0;
      addr_nxt    = ram_addr;
      wdata_nxt   = ram_wdata;
      issue       = 1'b0;
      deliver     = 1'b0;
`ifdef IRAM_FETCH_LIMIT_EN
      fault_nxt   = fault;
`endif

      unique case (state)
         IDLE: begin
            if (!pc_load) begin
               // tie goes to whoever did not win last time
               if (fetch_ok &&
                   (!host_wr || last_grant == GNT_HOST)) begin
                  last_nxt = GNT_FETCH;
`ifdef IRAM_FETCH_LIMIT_EN
                  if (pc >= pc_limit) begin
                     fault_nxt = 1'b1;
                  end else begin
                     issue = 1'b1;
                     if (&pc) fault_nxt = 1'b1;
                  end
`else
                  issue = 1'b1;
`endif
               end else if (host_wr) begin
                  last_nxt  = GNT_HOST;
                  en_nxt    = 1'b1;
                  we_nxt    = 1'b1;
                  addr_nxt  = host_addr;
                  wdata_nxt = host_data;
                  ack_nxt   = 1'b1;
                  state_nxt = HOST;
               end
            end
         end
         READ: begin
            if (lat_cnt != 3'd0) begin
               lat_nxt = lat_cnt - 3'd1;
            end else begin
               state_nxt = IDLE;
               // a pc_load during the read makes its byte stale
               if (!discard && !pc_load) begin
                  deliver  = 1'b1;
                  data_nxt = ram_rdata;
               end
            end
            if (pc_load) discard_nxt = 1'b1;
         end
         HOST: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (issue) begin
         en_nxt      = 1'b1;
         addr_nxt    = pc;
         pc_nxt      = pc + ADDR_W'(1);
         lat_nxt     = 3'(RD_LAT);
         discard_nxt = 1'b0;
         state_nxt   = READ;
      end

      if (pc_load) begin
         pc_nxt = pc_load_val;
`ifdef IRAM_FETCH_LIMIT_EN
         fault_nxt = 1'b0;
`endif
      end

      // stays up through a READ even if fetch_req drops meanwhile
      wait_nxt = deliver ? 1'b0
               : (fetch_req || (state == READ && waiting));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         lat_cnt    <= 3'd0;
         last_grant <= GNT_HOST;
         discard    <= 1'b0;
         pc         <= PC_RESET;
         iram_data  <= 8'h00;
         waiting    <= 1'b0;
         host_ack   <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= 8'h00;
`ifdef IRAM_FETCH_LIMIT_EN
         fault      <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         lat_cnt    <= lat_nxt;
         last_grant <= last_nxt;
         discard    <= discard_nxt;
         pc         <= pc_nxt;
         iram_data  <= data_nxt;
         waiting    <= wait_nxt;
         host_ack   <= ack_nxt;
         ram_en     <= en_nxt;
         ram_we     <= we_nxt;
         ram_addr   <= addr_nxt;
         ram_wdata  <= wdata_nxt;
`ifdef IRAM_FETCH_LIMIT_EN
         fault      <= fault_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Testbench for iram_fetch_arbiter: cycle vector table plus directed
// sequences for arbitration, pc_load during a read, wrap and reset.
module tb_iram_fetch_arbiter;

   localparam int AW = 12;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_req;
   logic [7:0]    iram_data;
   logic          waiting;
   logic [AW-1:0] pc;
   logic          pc_load;
   logic [AW-1:0] pc_load_val;
   logic          host_wr;
   logic [AW-1:0] host_addr;
   logic [7:0]    host_data;
   logic          host_ack;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iram_fetch_arbiter #(
      .ADDR_W  (AW),
      .RD_LAT  (RL),
      .PC_RESET(12'h000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_req  (fetch_req),
      .iram_data  (iram_data),
      .waiting    (waiting),
      .pc         (pc),
      .pc_load    (pc_load),
      .pc_load_val(pc_load_val),
      .host_wr    (host_wr),
      .host_addr  (host_addr),
      .host_data  (host_data),
      .host_ack   (host_ack),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   // RAM model: read data valid RL cycles after the ram_en cycle
   logic [7:0] mem [0:4095];
   logic [7:0] pipe [0:3];

   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr] = ram_wdata;
      pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : 8'h00;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
   end

   assign ram_rdata = pipe[RL-1];

   typedef struct {
      logic          rst;
      logic          freq;
      logic          ld;
      logic [AW-1:0] ldv;
      logic          hwr;
      logic [AW-1:0] ha;
      logic [7:0]    hd;
      logic [7:0]    e_data;
      logic          e_wait;
      logic [AW-1:0] e_pc;
      logic          e_en;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic          e_ack;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic r, input logic f, input logic l,
      input logic [AW-1:0] lv, input logic h,
      input logic [AW-1:0] ha, input logic [7:0] hd,
      input logic [7:0] ed, input logic ew,
      input logic [AW-1:0] ep, input logic een,
      input logic ewe, input logic [AW-1:0] ea,
      input logic eack);
      vec_t v;
      v.rst = r;  v.freq = f; v.ld = l; v.ldv = lv;
      v.hwr = h;  v.ha = ha;  v.hd = hd;
      v.e_data = ed; v.e_wait = ew; v.e_pc = ep;
      v.e_en = een;  v.e_we = ewe;  v.e_addr = ea;
      v.e_ack = eack;
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs;
      reset       = 1'b0;
      fetch_req   = 1'b0;
      pc_load     = 1'b0;
      pc_load_val = '0;
      host_wr     = 1'b0;
      host_addr   = '0;
      host_data   = 8'h00;
   endtask

   task automatic do_reset;
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_deliver(input int max, output int cyc);
      cyc = 0;
      while (waiting && cyc < max) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc;
      int   nf;
      int   nen;
      logic bad;
      logic [AW-1:0] en_addr;

      for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[12'h000] = 8'hC4;
      mem[12'h001] = 8'h15;
      mem[12'h005] = 8'h55;
      mem[12'h010] = 8'h00;
      mem[12'h100] = 8'h77;
      mem[12'hFFF] = 8'hEE;

      //       r f l ldv     h ha      hd     data  w pc      en we addr  ack
      vecs[0]  = mk(1,0,0,12'h000,0,12'h000,8'h00, 8'h00,0,12'h000,0,0,12'h000,0);
      vecs[1]  = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'h00,1,12'h001,1,0,12'h000,0);
      vecs[2]  = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'h00,1,12'h001,0,0,12'h000,0);
      vecs[3]  = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'h00,1,12'h001,0,0,12'h000,0);
      vecs[4]  = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'hC4,0,12'h001,0,0,12'h000,0);
      vecs[5]  = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'hC4,1,12'h002,1,0,12'h001,0);
      vecs[6]  = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'hC4,1,12'h002,0,0,12'h001,0);
      vecs[7]  = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'hC4,1,12'h002,0,0,12'h001,0);
      vecs[8]  = mk(0,0,0,12'h000,0,12'h000,8'h00, 8'h15,0,12'h002,0,0,12'h001,0);
      vecs[9]  = mk(0,0,0,12'h000,0,12'h000,8'h00, 8'h15,0,12'h002,0,0,12'h001,0);
      vecs[10] = mk(0,0,0,12'h000,1,12'h010,8'hB1, 8'h15,0,12'h002,1,1,12'h010,1);
      vecs[11] = mk(0,0,0,12'h000,0,12'h000,8'h00, 8'h15,0,12'h002,0,0,12'h010,0);
      vecs[12] = mk(0,0,1,12'h010,0,12'h000,8'h00, 8'h15,0,12'h010,0,0,12'h010,0);
      vecs[13] = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'h15,1,12'h011,1,0,12'h010,0);
      vecs[14] = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'h15,1,12'h011,0,0,12'h010,0);
      vecs[15] = mk(0,1,0,12'h000,0,12'h000,8'h00, 8'h15,1,12'h011,0,0,12'h010,0);
      vecs[16] = mk(0,0,0,12'h000,0,12'h000,8'h00, 8'hB1,0,12'h011,0,0,12'h010,0);
      vecs[17] = mk(0,0,0,12'h000,0,12'h000,8'h00, 8'hB1,0,12'h011,0,0,12'h010,0);

      clear_inputs();
      reset = 1'b1;

      // fetch 0xC4, 0x15, then host write 0xB1 at 0x010 and read it back
      for (int i = 0; i < NV; i++) begin
         reset       = vecs[i].rst;
         fetch_req   = vecs[i].freq;
         pc_load     = vecs[i].ld;
         pc_load_val = vecs[i].ldv;
         host_wr     = vecs[i].hwr;
         host_addr   = vecs[i].ha;
         host_data   = vecs[i].hd;
         tick();
         chk($sformatf("vec%0d", i),
             {iram_data, waiting, pc, ram_en, ram_we, ram_addr, host_ack},
             {vecs[i].e_data, vecs[i].e_wait, vecs[i].e_pc,
              vecs[i].e_en, vecs[i].e_we, vecs[i].e_addr,
              vecs[i].e_ack});
      end

      // round robin with both requesters held: F,H,F,H,...
      do_reset();
      fetch_req = 1'b1;
      host_wr   = 1'b1;
      host_addr = 12'h200;
      host_data = 8'h33;
      nf = 0;
      for (int g = 0; g < 16; g++) begin
         cyc = 0;
         do begin
            tick();
            cyc++;
         end while (!ram_en && cyc < 10);
         if (!ram_en) begin
            chk("rr_timeout", ram_en, 1'b1);
            break;
         end
         chk($sformatf("rr_grant%0d", g), ram_we, (g % 2 == 1));
         chk($sformatf("rr_ack%0d", g), host_ack, ram_we);
         if (!ram_we) begin
            chk($sformatf("rr_addr%0d", nf), ram_addr, nf);
            nf++;
         end
      end
      clear_inputs();

      // pc_load one cycle into a read at pc=5
      do_reset();
      fetch_req = 1'b1;
      tick();
      wait_deliver(10, cyc);
      fetch_req = 1'b0;
      chk("pl_pre_data", iram_data, 8'hC4);
      pc_load     = 1'b1;
      pc_load_val = 12'h005;
      tick();
      pc_load = 1'b0;
      fetch_req = 1'b1;
      tick();
      chk("pl_issue", {ram_en, ram_addr, pc}, {1'b1, 12'h005, 12'h006});
      pc_load     = 1'b1;
      pc_load_val = 12'h100;
      tick();
      pc_load = 1'b0;
      chk("pl_pc", pc, 12'h100);
      bad = 1'b0;
      nen = 0;
      en_addr = '0;
      cyc = 0;
      while (waiting && cyc < 12) begin
         tick();
         cyc++;
         if (ram_en) begin
            nen++;
            en_addr = ram_addr;
         end
         if (waiting && iram_data !== 8'hC4) bad = 1'b1;
      end
      fetch_req = 1'b0;
      chk("pl_timeout", waiting, 1'b0);
      chk("pl_held", bad, 1'b0);
      chk("pl_reissue", {nen[3:0], en_addr}, {4'd1, 12'h100});
      chk("pl_data", iram_data, 8'h77);
      chk("pl_pc_after", pc, 12'h101);

      // fetch at top of address space, fetch_req dropped mid-read
      pc_load     = 1'b1;
      pc_load_val = 12'hFFF;
      tick();
      pc_load   = 1'b0;
      fetch_req = 1'b1;
      tick();
      chk("wrap_issue", {ram_en, ram_addr}, {1'b1, 12'hFFF});
      chk("wrap_pc", pc, 12'h000);
      fetch_req = 1'b0;
      wait_deliver(10, cyc);
      chk("wrap_timeout", waiting, 1'b0);
      chk("wrap_data", iram_data, 8'hEE);
      tick();
      chk("wrap_idle", {ram_en, waiting}, 2'b00);

      // reset in the middle of a read at pc=0
      fetch_req = 1'b1;
      tick();
      tick();
      reset     = 1'b1;
      fetch_req = 1'b0;
      tick();
      chk("rst_mid",
          {iram_data, waiting, pc, ram_en, ram_we, ram_addr,
           host_ack, ram_wdata},
          {8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00});
      reset = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (iram_data !== 8'h00 || waiting || ram_en) bad = 1'b1;
      end
      chk("rst_late_data", bad, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
